// File: rtl/complex_div_arbiter_if.sv
// Bundle of requester-side and complex_div-side signals around the shared divider arbiter.
// master drives the requesters and models the divider; slave is the arbiter itself.
interface complex_div_arbiter_if #(
   parameter int unsigned NumReq = 4
);
   logic                          flush_i;
   logic [NumReq-1:0]             req_valid_i;
   logic [NumReq-1:0]             req_ready_o;
   logic [NumReq-1:0][3:0][63:0]  req_operands_i;
   logic [NumReq-1:0]             rsp_valid_o;
   logic [NumReq-1:0]             rsp_ready_i;
   logic [1:0][63:0]              rsp_result_o;
   logic [4:0]                    rsp_status_o;
   logic [3:0][63:0]              div_operands_o;
   logic                          div_in_valid_o;
   logic                          div_in_ready_i;
   logic                          div_flush_o;
   logic [1:0][63:0]              div_result_i;
   logic [4:0]                    div_status_i;
   logic                          div_out_valid_i;
   logic                          div_out_ready_o;
   logic                          div_busy_i;
   logic                          busy_o;
   logic                          err_o;

   modport master (
      output flush_i, req_valid_i, req_operands_i, rsp_ready_i,
             div_in_ready_i, div_result_i, div_status_i, div_out_valid_i, div_busy_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o, div_operands_o,
             div_in_valid_o, div_flush_o, div_out_ready_o, busy_o, err_o
   );

   modport slave (
      input  flush_i, req_valid_i, req_operands_i, rsp_ready_i,
             div_in_ready_i, div_result_i, div_status_i, div_out_valid_i, div_busy_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o, div_operands_o,
             div_in_valid_o, div_flush_o, div_out_ready_o, busy_o, err_o
   );
endinterface

// File: rtl/complex_div_arbiter.sv
// Round-robin arbiter sharing one untagged, in-order complex_div among NumReq requesters.
// An in-order ID FIFO remembers who issued each in-flight op so results route back to their owner.
module complex_div_arbiter #(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned MaxOutstanding = 4
) (
   input logic                 clk_i,
   input logic                 rst_i,
   complex_div_arbiter_if.slave bus
);
   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_e;

   lock_e             state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   grant_q, grant_d;
   logic [IdxW-1:0]   id_fifo_q [MaxOutstanding];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              err_q;

   logic [IdxW-1:0]   cand, search_win, winner, head;
   logic              found, full, empty, can_issue;
   logic              in_valid, out_ready, push, pop, err_set;
   logic [NumReq-1:0] req_ready, rsp_valid;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // First valid requester at or above rr_ptr, wrapping.
   always_comb begin
      found      = 1'b0;
      cand       = '0;
      search_win = rr_ptr_q;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = IdxW'((32'(rr_ptr_q) + i) % NumReq);
         if (!found && bus.req_valid_i[cand]) begin
            found      = 1'b1;
            search_win = cand;
         end
      end
   end

   // Lock FSM next state plus issue/response steering.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      winner    = search_win;
      in_valid  = 1'b0;
      req_ready = '0;
      rsp_valid = '0;
      out_ready = 1'b0;

      full      = (count_q == CntW'(MaxOutstanding));
      empty     = (count_q == '0);
      can_issue = !full && !bus.flush_i && !rst_i;

      case (state_q)
         ST_OPEN: begin
            winner   = search_win;
            in_valid = can_issue && found;
         end
         ST_LOCKED: begin
            winner   = grant_q;
            in_valid = can_issue;
         end
         default: ;
      endcase

      push = in_valid && bus.div_in_ready_i;
      if (push) req_ready[winner] = 1'b1;

      // Empty FIFO drains stray results so a misbehaving unit cannot wedge.
      head = id_fifo_q[rd_ptr_q];
      if (!rst_i && !bus.flush_i) begin
         if (empty) begin
            out_ready = 1'b1;
         end else begin
            out_ready       = bus.rsp_ready_i[head];
            rsp_valid[head] = bus.div_out_valid_i;
         end
      end
      pop     = bus.div_out_valid_i && out_ready && !empty;
      err_set = bus.div_out_valid_i && out_ready && empty;

      if (push) rr_ptr_d = (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);

      if (bus.flush_i || push) begin
         state_d = ST_OPEN;
      end else if (in_valid) begin
         state_d = ST_LOCKED;
         grant_d = winner;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_OPEN;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Occupancy and ID FIFO pointers; flush discards all tracked IDs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) id_fifo_q[wr_ptr_q] <= winner;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign bus.req_ready_o     = req_ready;
   assign bus.div_in_valid_o  = in_valid;
   assign bus.div_operands_o  = bus.req_operands_i[winner];
   assign bus.rsp_valid_o     = rsp_valid;
   assign bus.div_out_ready_o = out_ready;
   assign bus.rsp_result_o    = bus.div_result_i;
   assign bus.rsp_status_o    = bus.div_status_i;
   assign bus.div_flush_o     = bus.flush_i && !rst_i;
   assign bus.busy_o          = (count_q != '0) || (state_q == ST_LOCKED) || bus.div_busy_i;
   assign bus.err_o           = err_q;
endmodule

// File: doc/complex_div_arbiter.md
Name: complex_div_arbiter

Overview:
- Shares one complex_div unit (operands {b2,a2,b1,a1}, 2x64 result, fpnew status, valid/ready on both sides) among NumReq requesters.
- Uses round-robin arbitration on the input side.
- Tracks the requester ID of every in-flight operation in an in-order ID FIFO. complex_div returns results in issue order and carries no tag, so the FIFO head identifies the owner of each result.
- Sits between the requesting lanes and the complex_div instance. The arbiter adds zero cycles of latency on either side.

Parameters:
- NumReq, 4, number of requesters; legal range 2..16.
- MaxOutstanding, 4, maximum operations in flight inside complex_div; this is also the ID FIFO depth; legal range 1..16.
- IdxW, max(1,$clog2(NumReq)), derived; width of a requester index.
- CntW, $clog2(MaxOutstanding+1), derived; width of the occupancy counter.

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  kill all in-flight work.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester request accepted; at most one bit high.
- req_operands_i  in  NumReq x 4 x 64  per-requester {b2,a2,b1,a1}.
- rsp_valid_o  out  NumReq  per-requester result valid; at most one bit high.
- rsp_ready_i  in  NumReq  per-requester result ready.
- rsp_result_o  out  2x64  shared result bus; meaningful only for the requester whose rsp_valid_o is set.
- rsp_status_o  out  5  shared fpnew_pkg::status_t.
- div_operands_o  out  4x64  to complex_div operands_i.
- div_in_valid_o  out  1  to complex_div in_valid_i.
- div_in_ready_i  in  1  from complex_div in_ready_o.
- div_flush_o  out  1  to complex_div flush_i.
- div_result_i  in  2x64  from complex_div result_o.
- div_status_i  in  5  from complex_div status_o.
- div_out_valid_i  in  1  from complex_div out_valid_o.
- div_out_ready_o  out  1  to complex_div out_ready_i.
- div_busy_i  in  1  from complex_div busy_o.
- busy_o  out  1  arbiter or unit holds work.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset state: rr_ptr=0, lock_q=0, grant_q=0, FIFO empty, count=0, err_o=0. While reset is asserted all valid/ready outputs are 0, busy_o follows div_busy_i, div_flush_o=0.
- can_issue = (count < MaxOutstanding) & !flush_i.
- Arbitration, when lock_q=0:
  - winner = first requester with req_valid_i set, searching from rr_ptr upward with wrap at NumReq-1 -> 0.
  - div_in_valid_o = can_issue & (any req_valid_i).
- Arbitration, when lock_q=1: winner = grant_q and div_in_valid_o = can_issue.
- div_operands_o = req_operands_i[winner].
- req_ready_o[winner] = div_in_valid_o & div_in_ready_i; all other bits are 0.
- Lock rule: if div_in_valid_o=1 and div_in_ready_i=0, then set lock_q=1 and grant_q=winner. The grant must not move until the handshake completes. Requesters hold valid and operands stable until their ready bit is seen.
- Issue handshake (div_in_valid_o & div_in_ready_i):
  - push winner into the FIFO;
  - rr_ptr <= winner+1, wrapping to 0;
  - lock_q <= 0.
- Response side, FIFO non-empty, head=h:
  - rsp_valid_o[h] = div_out_valid_i & !flush_i;
  - div_out_ready_o = rsp_ready_i[h];
  - rsp_result_o and rsp_status_o pass through from div_result_i and div_status_i.
- Response handshake (div_out_valid_i & div_out_ready_o & FIFO non-empty): pop the FIFO.
- Response side, FIFO empty while div_out_valid_i=1 is a protocol error:
  - div_out_ready_o=1, so the result is drained;
  - all rsp_valid_o=0;
  - err_o <= 1, held until reset.
- Counter rules:
  - push and pop in the same cycle leave count unchanged;
  - push alone increments count;
  - pop alone decrements count;
  - count never exceeds MaxOutstanding.
  - FIFO pointers wrap modulo MaxOutstanding.
- Full FIFO: div_in_valid_o=0 and req_ready_o=0; any existing lock is retained.
- Flush:
  - div_flush_o = flush_i, combinationally;
  - in the flush cycle no handshake occurs on either side;
  - next state: FIFO empty, count=0, lock_q=0; rr_ptr is retained; err_o is unaffected.
- busy_o = (count != 0) | lock_q | div_busy_i.
- Reset asserted mid-operation: state clears immediately (asynchronous); in-flight results arriving after release trigger err_o. Flushing the unit before releasing reset is the integrator's responsibility.

Test Plan:
- NumReq=4, all req_valid_i=1, div_in_ready_i=1, result ready stuck 1 -> grants go 0,1,2,3,0,… one per cycle until count=4; then issue stalls; each result routes to IDs 0,1,2,3 in order.
- Req 2 valid, div_in_ready_i=0 for 3 cycles while req 1 becomes valid in cycle 2 -> grant stays on 2 and div_operands_o stays stable; req_ready_o=4'b0100 on the handshake cycle; req 1 is granted next.
- MaxOutstanding=4: issue 4 operations with no results returned -> count=4, div_in_valid_o=0. Then in one cycle, one pop plus a pending request -> next-cycle issue; count returns to 4.
- Same-cycle issue and response handshake at count=2 -> count stays 2; FIFO head advances; the new ID lands at the tail.
- Two in flight, then flush_i pulsed for 1 cycle -> div_flush_o=1 that cycle, no ready asserted; next cycle count=0, lock_q=0, busy_o=div_busy_i.
- FIFO empty, div_out_valid_i=1 with result 128'h1 -> div_out_ready_o=1, rsp_valid_o=0, err_o=1 from the next cycle until rst_i.
